// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler.
//  - config register indices inside a voice's 4-register window
//  - slot classification derived from the frame counter
//  - datapath widths
//  - nibble normalisation applied to raw LUT data before volume scaling
package voice_scheduler_pkg;

  // cfg_addr_in = {voice[1:0], reg[1:0]}
  localparam logic [1:0] REG_FREQ  = 2'd0;  // freq[15:0]
  localparam logic [1:0] REG_CTRL  = 2'd1;  // {type[6:4], vol[3:0]}
  localparam logic [1:0] REG_KEY   = 2'd2;  // keyon[0]
  localparam logic [1:0] REG_PHASE = 2'd3;  // direct phase load

  localparam int LUT_AW = 5;   // LUT address width
  localparam int WT_W   = 3;   // wave type width
  localparam int ACC_W  = 10;  // mix accumulator width (4 * 15 * 15 = 900 fits)

  // What the scheduler is doing in the current clock, decoded from fcnt.
  typedef enum logic [1:0] {
    SLOT_VOICE = 2'd0,  // fcnt == v, v < NUM_VOICES
    SLOT_MIX   = 2'd1,  // fcnt == NUM_VOICES
    SLOT_IDLE  = 2'd2   // every other fcnt value
  } slot_e;

  // Wave types with bit 2 set carry a 4-bit level in the top nibble;
  // the others are 1-bit waves whose level lives in bit 0.
  function automatic logic [3:0] norm_nib(input logic [15:0] data, input logic wide);
    return wide ? data[15:12] : {4{data[0]}};
  endfunction

endpackage

// File: rtl/voice_scheduler_regfile.sv
// Per-voice configuration and phase storage.
// Ports:
//  clk_in, reset_in          clock, async active-high reset
//  cfg_we_in/addr/data       config write port {voice[1:0], reg[1:0]}
//  i_inc_en, i_inc_voice     advance phase of one voice by its freq this clock
//  o_addr                    per-voice LUT address (top 5 phase bits)
//  o_type, o_vol, o_keyon    per-voice control fields
// A REG_PHASE write in the same clock as the increment of that voice wins.
module voice_regfile
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16
) (
  input  logic                                clk_in,
  input  logic                                reset_in,
  input  logic                                cfg_we_in,
  input  logic [3:0]                          cfg_addr_in,
  input  logic [15:0]                         cfg_data_in,
  input  logic                                i_inc_en,
  input  logic [1:0]                          i_inc_voice,
  output logic [NUM_VOICES-1:0][LUT_AW-1:0]   o_addr,
  output logic [NUM_VOICES-1:0][WT_W-1:0]     o_type,
  output logic [NUM_VOICES-1:0][3:0]          o_vol,
  output logic [NUM_VOICES-1:0]               o_keyon
);

  logic [NUM_VOICES-1:0][PHASE_W-1:0] r_phase;
  logic [NUM_VOICES-1:0][15:0]        r_freq;
  logic [NUM_VOICES-1:0][WT_W-1:0]    r_type;
  logic [NUM_VOICES-1:0][3:0]         r_vol;
  logic [NUM_VOICES-1:0]              r_keyon;

  logic [1:0] w_voice;
  logic [1:0] w_reg;

  assign w_voice = cfg_addr_in[3:2];
  assign w_reg   = cfg_addr_in[1:0];

  // Voice indices >= NUM_VOICES never match the loop, so those writes drop.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_phase <= '0;
      r_freq  <= '0;
      r_type  <= '0;
      r_vol   <= '0;
      r_keyon <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (i_inc_en && i_inc_voice == 2'(v)) begin
          r_phase[v] <= r_phase[v] + PHASE_W'(r_freq[v]);
        end
        // Placed after the increment so a phase load overrides it.
        if (cfg_we_in && w_voice == 2'(v)) begin
          case (w_reg)
            REG_FREQ:  r_freq[v] <= cfg_data_in;
            REG_CTRL: begin
              r_type[v] <= cfg_data_in[6:4];
              r_vol[v]  <= cfg_data_in[3:0];
            end
            REG_KEY:   r_keyon[v] <= cfg_data_in[0];
            REG_PHASE: r_phase[v] <= PHASE_W'(cfg_data_in);
            default:   ;
          endcase
        end
      end
    end
  end

  always_comb begin
    o_addr = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      o_addr[v] = r_phase[v][PHASE_W-1 -: LUT_AW];
    end
  end

  assign o_type  = r_type;
  assign o_vol   = r_vol;
  assign o_keyon = r_keyon;

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes one external wave LUT across NUM_VOICES voices and mixes
// the volume-scaled results into one sample per frame of SAMPLE_DIV clocks.
// Also arbitrates the LUT's wave-memory write port, granting only in idle slots.
// Ports:
//  clk_in, reset_in                  clock, async active-high reset
//  cfg_we_in/addr_in/data_in         per-voice config writes
//  wmem_req_in/addr_in/data_in       wave-memory write request (held until ack)
//  wmem_ack_out                      one-clock grant
//  lut_addr_out, wave_type_out       LUT read address for the active voice
//  lut_data_in                       combinational LUT read data
//  mem_write_*_out                   LUT memory write port
//  sample_out, sample_valid_out      mixed sample and its one-clock strobe
// Handshake: a wave-memory write is accepted on a clock edge where wmem_req_in
// is high, no ack is currently being shown, and the following clock lies in
// the write window (NUM_VOICES+1 .. SAMPLE_DIV-2); ack/en are then high for
// exactly that following clock, and the requester may change req afterwards.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int SAMPLE_DIV = 64
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        cfg_we_in,
  input  logic [3:0]  cfg_addr_in,
  input  logic [15:0] cfg_data_in,
  input  logic        wmem_req_in,
  input  logic [4:0]  wmem_addr_in,
  input  logic [3:0]  wmem_data_in,
  output logic        wmem_ack_out,
  output logic [4:0]  lut_addr_out,
  output logic [2:0]  wave_type_out,
  input  logic [15:0] lut_data_in,
  output logic [4:0]  mem_write_addr_out,
  output logic [3:0]  mem_write_data_out,
  output logic        mem_write_en_out,
  output logic [15:0] sample_out,
  output logic        sample_valid_out
);

  localparam int FW = $clog2(SAMPLE_DIV);
  localparam logic [FW-1:0] LAST_CNT = FW'(SAMPLE_DIV - 1);
  localparam logic [FW-1:0] MIX_CNT  = FW'(NUM_VOICES);
  localparam logic [FW-1:0] WIN_LO   = FW'(NUM_VOICES + 1);
  localparam logic [FW-1:0] WIN_HI   = FW'(SAMPLE_DIV - 2);

  logic [FW-1:0]      r_fcnt;
  logic [ACC_W-1:0]   r_acc;
  logic [LUT_AW-1:0]  r_lut_addr;
  logic [WT_W-1:0]    r_wave_type;
  logic [15:0]        r_sample;
  logic               r_sample_valid;
  logic               r_grant;
  logic [4:0]         r_mem_addr;
  logic [3:0]         r_mem_data;

  logic [FW-1:0]      w_fcnt_next;
  slot_e              w_slot;
  logic               w_next_is_voice;
  logic [LUT_AW-1:0]  w_next_addr;
  logic [WT_W-1:0]    w_next_type;
  logic [3:0]         w_cur_vol;
  logic               w_cur_keyon;
  logic [3:0]         w_nib;
  logic [7:0]         w_contrib;
  logic               w_grant;

  logic [NUM_VOICES-1:0][LUT_AW-1:0] w_voice_addr;
  logic [NUM_VOICES-1:0][WT_W-1:0]   w_voice_type;
  logic [NUM_VOICES-1:0][3:0]        w_voice_vol;
  logic [NUM_VOICES-1:0]             w_voice_keyon;

  voice_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W)
  ) u_regfile (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .cfg_we_in   (cfg_we_in),
    .cfg_addr_in (cfg_addr_in),
    .cfg_data_in (cfg_data_in),
    .i_inc_en    (w_slot == SLOT_VOICE),
    .i_inc_voice (r_fcnt[1:0]),
    .o_addr      (w_voice_addr),
    .o_type      (w_voice_type),
    .o_vol       (w_voice_vol),
    .o_keyon     (w_voice_keyon)
  );

  assign w_fcnt_next = (r_fcnt == LAST_CNT) ? '0 : r_fcnt + 1'b1;

  always_comb begin
    w_slot = SLOT_IDLE;
    if (r_fcnt < MIX_CNT) begin
      w_slot = SLOT_VOICE;
    end else if (r_fcnt == MIX_CNT) begin
      w_slot = SLOT_MIX;
    end
  end

  // The LUT address/type registers are loaded one clock ahead so the voice's
  // values are on the outputs for the whole of its slot; lut_data_in is then
  // consumed in that same slot.
  always_comb begin
    w_next_is_voice = 1'b0;
    w_next_addr     = '0;
    w_next_type     = '0;
    w_cur_vol       = '0;
    w_cur_keyon     = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (w_fcnt_next == FW'(v)) begin
        w_next_is_voice = 1'b1;
        w_next_addr     = w_voice_addr[v];
        w_next_type     = w_voice_type[v];
      end
      if (r_fcnt == FW'(v)) begin
        w_cur_vol   = w_voice_vol[v];
        w_cur_keyon = w_voice_keyon[v];
      end
    end
  end

  // The registered wave type is the one the LUT is answering for.
  assign w_nib     = norm_nib(lut_data_in, r_wave_type[2]);
  assign w_contrib = w_cur_keyon ? ({4'b0, w_nib} * {4'b0, w_cur_vol}) : 8'd0;

  assign w_grant = wmem_req_in && !r_grant &&
                   (w_fcnt_next >= WIN_LO) && (w_fcnt_next <= WIN_HI);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_fcnt         <= '0;
      r_acc          <= '0;
      r_lut_addr     <= '0;
      r_wave_type    <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_grant        <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data     <= '0;
    end else begin
      r_fcnt <= w_fcnt_next;

      r_lut_addr  <= w_next_is_voice ? w_next_addr : '0;
      r_wave_type <= w_next_is_voice ? w_next_type : '0;

      if (w_slot == SLOT_VOICE) begin
        // Slot 0 starts a fresh sum instead of adding to last frame's.
        r_acc <= ((r_fcnt == '0) ? '0 : r_acc) + ACC_W'(w_contrib);
      end

      r_sample_valid <= (w_slot == SLOT_MIX);
      if (w_slot == SLOT_MIX) begin
        r_sample <= {r_acc, 6'b0};
      end

      r_grant <= w_grant;
      if (w_grant) begin
        r_mem_addr <= wmem_addr_in;
        r_mem_data <= wmem_data_in;
      end
    end
  end

  assign lut_addr_out       = r_lut_addr;
  assign wave_type_out      = r_wave_type;
  assign sample_out         = r_sample;
  assign sample_valid_out   = r_sample_valid;
  assign wmem_ack_out       = r_grant;
  assign mem_write_en_out   = r_grant;
  assign mem_write_addr_out = r_mem_addr;
  assign mem_write_data_out = r_mem_data;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

  localparam int N  = 4;
  localparam int SD = 64;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic        cfg_we_in = 1'b0;
  logic [3:0]  cfg_addr_in = '0;
  logic [15:0] cfg_data_in = '0;
  logic        wmem_req_in = 1'b0;
  logic [4:0]  wmem_addr_in = '0;
  logic [3:0]  wmem_data_in = '0;
  logic        wmem_ack_out;
  logic [4:0]  lut_addr_out;
  logic [2:0]  wave_type_out;
  logic [15:0] lut_data_in;
  logic [4:0]  mem_write_addr_out;
  logic [3:0]  mem_write_data_out;
  logic        mem_write_en_out;
  logic [15:0] sample_out;
  logic        sample_valid_out;

  voice_scheduler #(.NUM_VOICES(N), .PHASE_W(16), .SAMPLE_DIV(SD)) dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .cfg_we_in          (cfg_we_in),
    .cfg_addr_in        (cfg_addr_in),
    .cfg_data_in        (cfg_data_in),
    .wmem_req_in        (wmem_req_in),
    .wmem_addr_in       (wmem_addr_in),
    .wmem_data_in       (wmem_data_in),
    .wmem_ack_out       (wmem_ack_out),
    .lut_addr_out       (lut_addr_out),
    .wave_type_out      (wave_type_out),
    .lut_data_in        (lut_data_in),
    .mem_write_addr_out (mem_write_addr_out),
    .mem_write_data_out (mem_write_data_out),
    .mem_write_en_out   (mem_write_en_out),
    .sample_out         (sample_out),
    .sample_valid_out   (sample_valid_out)
  );

  // ---------------- LUT environment ----------------
  // mode 0: random table; mode 1: type4 -> 0xF000 everywhere, type0 -> square (addr>=16 high)
  logic [15:0] lut_rom [8][32];
  int lut_mode = 1;
  assign lut_data_in = (lut_mode == 0) ? lut_rom[wave_type_out][lut_addr_out] :
                       (wave_type_out[2] ? 16'hF000 : {16{lut_addr_out[4]}});

  function automatic int lut_value(input int t, input int a);
    logic [15:0] d;
    if (lut_mode == 0) d = lut_rom[t][a];
    else if (t >= 4) d = 16'hF000;
    else d = (a >= 16) ? 16'hFFFF : 16'h0000;
    return int'(d);
  endfunction

  // ---------------- reference model ----------------
  int m_fcnt, m_acc, m_sample, m_valid, m_ack, m_wa, m_wd;
  int m_phase [N];
  int m_freq [N];
  int m_vol [N];
  int m_type [N];
  int m_key [N];

  int n_pass = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit auto_req = 0;
  bit auto_cfg = 0;

  task automatic model_reset();
    m_fcnt = 0; m_acc = 0; m_sample = 0; m_valid = 0; m_ack = 0; m_wa = 0; m_wd = 0;
    for (int v = 0; v < N; v++) begin
      m_phase[v] = 0; m_freq[v] = 0; m_vol[v] = 0; m_type[v] = 0; m_key[v] = 0;
    end
  endtask

  function automatic int exp_addr();
    return (m_fcnt < N) ? ((m_phase[m_fcnt] >> 11) & 31) : 0;
  endfunction

  function automatic int exp_type();
    return (m_fcnt < N) ? m_type[m_fcnt] : 0;
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_advance();
    int f, nf, d, nib, contrib, grant;
    f = m_fcnt;
    nf = (f + 1) % SD;
    if (f < N) begin
      d = lut_value(exp_type(), exp_addr());
      nib = (m_type[f] >= 4) ? ((d >> 12) & 15) : (((d & 1) != 0) ? 15 : 0);
      contrib = (m_key[f] != 0) ? nib * m_vol[f] : 0;
      m_acc = ((f == 0) ? 0 : m_acc) + contrib;
      m_phase[f] = (m_phase[f] + m_freq[f]) % 65536;
    end
    if (f == N) m_sample = m_acc * 64;
    grant = (wmem_req_in && m_ack == 0 && nf >= N + 1 && nf <= SD - 2) ? 1 : 0;
    if (grant != 0) begin
      m_wa = int'(wmem_addr_in);
      m_wd = int'(wmem_data_in);
    end
    if (cfg_we_in && int'(cfg_addr_in[3:2]) < N) begin
      case (cfg_addr_in[1:0])
        2'd0: m_freq[cfg_addr_in[3:2]] = int'(cfg_data_in);
        2'd1: begin
          m_type[cfg_addr_in[3:2]] = int'(cfg_data_in[6:4]);
          m_vol[cfg_addr_in[3:2]]  = int'(cfg_data_in[3:0]);
        end
        2'd2: m_key[cfg_addr_in[3:2]] = int'(cfg_data_in[0]);
        default: m_phase[cfg_addr_in[3:2]] = int'(cfg_data_in);
      endcase
    end
    m_ack = grant;
    m_valid = (f == N) ? 1 : 0;
    m_fcnt = nf;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (fcnt %0d)", tag, obs, exp, m_fcnt);
    end
  endtask

  task automatic check_outputs();
    check("lut_addr",  int'(lut_addr_out), exp_addr());
    check("wave_type", int'(wave_type_out), exp_type());
    check("sample",    int'(sample_out), m_sample);
    check("valid",     int'(sample_valid_out), m_valid);
    check("ack",       int'(wmem_ack_out), m_ack);
    check("wr_en",     int'(mem_write_en_out), m_ack);
    check("wr_addr",   int'(mem_write_addr_out), m_wa);
    check("wr_data",   int'(mem_write_data_out), m_wd);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: check this cycle, apply stimulus, advance, move on.
  task automatic step();
    int v;
    check_outputs();
    if (auto_req) begin
      if (m_ack != 0) begin
        wmem_req_in  = 1'($urandom_range(0, 1));
        wmem_addr_in = 5'($urandom);
        wmem_data_in = 4'($urandom);
      end else if (!wmem_req_in && $urandom_range(0, 3) == 0) begin
        wmem_req_in  = 1'b1;
        wmem_addr_in = 5'($urandom);
        wmem_data_in = 4'($urandom);
      end
    end
    // Slot-time writes only target the active voice; the last IDLE clock is
    // left alone because voice 0's LUT address is captured there.
    if (auto_cfg && $urandom_range(0, 7) == 0 && m_fcnt <= SD - 2) begin
      v = (m_fcnt < N) ? m_fcnt : $urandom_range(0, N - 1);
      cfg_we_in   = 1'b1;
      cfg_addr_in = {2'(v), 2'($urandom_range(0, 3))};
      cfg_data_in = 16'($urandom);
    end
    model_advance();
    @(negedge clk_in);
    cfg_we_in = 1'b0;
  endtask

  task automatic step_until_fcnt(input int f);
    int guard = 0;
    while (m_fcnt != f && guard < 2 * SD) begin
      step();
      guard++;
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    int guard = 0;
    while ((m_fcnt < N || m_fcnt > SD - 2) && guard < 2 * SD) begin
      step();
      guard++;
    end
    cfg_we_in = 1'b1; cfg_addr_in = a; cfg_data_in = d;
    step();
  endtask

  task automatic reset_now();
    reset_in = 1'b1;
    #1;
    check("rst_lut_addr", int'(lut_addr_out), 0);
    check("rst_type",     int'(wave_type_out), 0);
    check("rst_sample",   int'(sample_out), 0);
    check("rst_valid",    int'(sample_valid_out), 0);
    check("rst_ack",      int'(wmem_ack_out), 0);
    check("rst_en",       int'(mem_write_en_out), 0);
    check("rst_waddr",    int'(mem_write_addr_out), 0);
    check("rst_wdata",    int'(mem_write_data_out), 0);
    model_reset();
    cfg_we_in = 1'b0; wmem_req_in = 1'b0;
    @(negedge clk_in);
    reset_in = 1'b0;  // this clock is fcnt == 0
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt;
    int exp6 [3];
    exp6[0] = 0; exp6[1] = 31; exp6[2] = 31;
    for (int t = 0; t < 8; t++)
      for (int a = 0; a < 32; a++) lut_rom[t][a] = 16'($urandom);

    @(negedge clk_in);
    reset_now();

    // Voice 0 full-scale constant wave: 225 per frame, address walks +1 per frame.
    cfg_write(4'b0000, 16'h0800);
    cfg_write(4'b0001, 16'h004F);
    cfg_write(4'b0010, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      step_until_fcnt(0);
      check("t2_addr_walk", int'(lut_addr_out), k);
      step_until_fcnt(N + 1);
      check("t2_sample", int'(sample_out), 16'h3840);
    end

    // All voices square wave at phase 0x8000.
    for (int v = 0; v < N; v++) begin
      cfg_write({2'(v), 2'd0}, 16'h0000);
      cfg_write({2'(v), 2'd1}, 16'h000F);
      cfg_write({2'(v), 2'd3}, 16'h8000);
      cfg_write({2'(v), 2'd2}, 16'h0001);
    end
    step_until_fcnt(N + 2);
    step_until_fcnt(N + 1);
    check("t3_all_on", int'(sample_out), 16'hE100);
    cfg_write(4'b1010, 16'h0000);
    step_until_fcnt(N + 2);
    step_until_fcnt(N + 1);
    check("t3_v2_off", int'(sample_out), 16'hA8C0);

    // Reset in the middle of a frame.
    step_until_fcnt(2);
    reset_now();
    cnt = 0;
    while (sample_valid_out !== 1'b1 && cnt < 2 * SD) begin
      step();
      cnt++;
    end
    check("t1_first_valid_delay", cnt, N + 1);

    // Wave-memory grants.
    step_until_fcnt(0);
    wmem_req_in = 1'b1; wmem_addr_in = 5'd5; wmem_data_in = 4'd9;
    cnt = 0;
    while (wmem_ack_out !== 1'b1 && cnt < 2 * SD) begin
      step();
      cnt++;
    end
    check("t4_first_ack_fcnt", cnt, N + 1);
    check("t4_wr_addr", int'(mem_write_addr_out), 5);
    wmem_addr_in = 5'd6; wmem_data_in = 4'd3;
    step();
    cnt = 1;
    while (wmem_ack_out !== 1'b1 && cnt < 2 * SD) begin
      step();
      cnt++;
    end
    check("t4_b2b_spacing", cnt, 2);
    check("t4_wr_data", int'(mem_write_data_out), 3);
    wmem_req_in = 1'b0;

    // Phase load during voice 1's own slot beats the increment.
    cfg_write(4'b0100, 16'h0100);
    step_until_fcnt(1);
    cfg_we_in = 1'b1; cfg_addr_in = 4'b0111; cfg_data_in = 16'h1234;
    step();
    step_until_fcnt(1);
    check("t5_phase_load", int'(lut_addr_out), (16'h1234 >> 11));
    step();
    step_until_fcnt(1);
    check("t5_phase_next", int'(lut_addr_out), (16'h1334 >> 11));

    // Wrap modulo 2^16 on voice 3.
    cfg_write(4'b1100, 16'hFFFF);
    cfg_write(4'b1111, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      step_until_fcnt(3);
      check("t6_wrap", int'(lut_addr_out), exp6[k]);
      step();
    end

    // Randomized traffic against the model.
    lut_mode = 0;
    auto_req = 1;
    auto_cfg = 1;
    repeat (40 * SD) step();
    auto_req = 0;
    auto_cfg = 0;
    wmem_req_in = 1'b0;
    repeat (SD) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
